// File: rtl/pc_sequencer_pkg.sv
// ---------------------------------------------------------------------------
// pc_sequencer_pkg
// Shared constants for the program-counter sequencer and its return-address
// stack: default widths/depths and a pointer-width helper that stays legal
// for a single-entry stack.
// ---------------------------------------------------------------------------
package pc_sequencer_pkg;

   localparam int PC_W_DEFAULT      = 16;
   localparam int LUT_DEPTH_DEFAULT = 32;
   localparam int RAS_DEPTH_DEFAULT = 4;

   // Width of a pointer into a buffer of 'depth' entries; never below 1 bit.
   function automatic int ptr_width(input int depth);
      if (depth > 1) begin
         return $clog2(depth);
      end else begin
         return 1;
      end
   endfunction

endpackage

// File: rtl/ret_addr_stack.sv
// ---------------------------------------------------------------------------
// ret_addr_stack
// Circular return-address stack. A push when full overwrites the oldest
// entry (the count saturates at DEPTH); a pop when empty is ignored.
// Ports:
//   clk        clock
//   rst        synchronous active-high reset (empties the stack)
//   push       write push_data on top
//   pop        remove the top entry
//   push_data  address to push
//   top_data   current top entry (valid when !empty)
//   full       count == DEPTH
//   empty      count == 0
// ---------------------------------------------------------------------------
module ret_addr_stack
   import pc_sequencer_pkg::*;
#(
   parameter int DEPTH = RAS_DEPTH_DEFAULT,
   parameter int W     = PC_W_DEFAULT
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic         pop,
   input  logic [W-1:0] push_data,
   output logic [W-1:0] top_data,
   output logic         full,
   output logic         empty
);

   localparam int PTR_W = ptr_width(DEPTH);
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   logic [W-1:0]     mem_r [DEPTH];
   logic [PTR_W-1:0] top_ptr_r;   // next free slot; top entry sits one below
   logic [CNT_W-1:0] count_r;
   logic [PTR_W-1:0] ptr_inc_s;
   logic [PTR_W-1:0] ptr_dec_s;

   // Circular pointer arithmetic, valid for non-power-of-two depths.
   always_comb begin
      ptr_inc_s = top_ptr_r + PTR_W'(1);
      ptr_dec_s = top_ptr_r - PTR_W'(1);
      if (top_ptr_r == LAST_PTR) begin
         ptr_inc_s = '0;
      end else begin
         ptr_inc_s = top_ptr_r + PTR_W'(1);
      end
      if (top_ptr_r == '0) begin
         ptr_dec_s = LAST_PTR;
      end else begin
         ptr_dec_s = top_ptr_r - PTR_W'(1);
      end
   end

   assign top_data = mem_r[ptr_dec_s];
   assign full     = (count_r == FULL_CNT);
   assign empty    = (count_r == '0);

   // Stack storage, pointer and occupancy count.
   always_ff @(posedge clk) begin
      if (rst) begin
         top_ptr_r <= '0;
         count_r   <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            mem_r[i] <= '0;
         end
      end else if (push) begin
         // On a full push the slot being written holds the oldest entry.
         mem_r[top_ptr_r] <= push_data;
         top_ptr_r        <= ptr_inc_s;
         if (!full) begin
            count_r <= count_r + CNT_W'(1);
         end
      end else if (pop && !empty) begin
         top_ptr_r <= ptr_dec_s;
         count_r   <= count_r - CNT_W'(1);
      end
   end

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
// Program counter with a runtime-writable branch-target table, a registered
// zero flag and a hardware return-address stack. All outputs are registers.
// Ports:
//   CLK           clock
//   START         synchronous active-high reset (overrides everything)
//   stall         freeze PC and stack this cycle
//   halt          stop execution, DONE rises next cycle
//   br_abs        PC <= T
//   br_rel_z      PC <= PC+T when zero_flag=1
//   br_rel_nz     PC <= PC+T when zero_flag=0
//   call          push PC+1, PC <= T
//   ret           pop into PC (PC+1 and underflow when empty)
//   lut_idx       target-table read index, T = lut[lut_idx]
//   flag_we       load zero flag from flag_zero_in
//   flag_zero_in  new zero-flag value
//   lut_we        target-table write enable
//   lut_waddr     target-table write index
//   lut_wdata     target-table write data
//   PC            current instruction address
//   DONE          sticky halted indication
//   zero_flag     registered zero flag
//   ras_overflow  sticky: call pushed into a full stack
//   ras_underflow sticky: ret on an empty stack
// ---------------------------------------------------------------------------
module pc_sequencer
   import pc_sequencer_pkg::*;
#(
   parameter int PC_W      = PC_W_DEFAULT,
   parameter int LUT_DEPTH = LUT_DEPTH_DEFAULT,
   parameter int RAS_DEPTH = RAS_DEPTH_DEFAULT
) (
   input  logic                         CLK,
   input  logic                         START,
   input  logic                         stall,
   input  logic                         halt,
   input  logic                         br_abs,
   input  logic                         br_rel_z,
   input  logic                         br_rel_nz,
   input  logic                         call,
   input  logic                         ret,
   input  logic [$clog2(LUT_DEPTH)-1:0] lut_idx,
   input  logic                         flag_we,
   input  logic                         flag_zero_in,
   input  logic                         lut_we,
   input  logic [$clog2(LUT_DEPTH)-1:0] lut_waddr,
   input  logic [PC_W-1:0]              lut_wdata,
   output logic [PC_W-1:0]              PC,
   output logic                         DONE,
   output logic                         zero_flag,
   output logic                         ras_overflow,
   output logic                         ras_underflow
);

   logic [PC_W-1:0] lut_r [LUT_DEPTH];
   logic [PC_W-1:0] pc_r;
   logic            done_r;
   logic            zero_r;
   logic            ovf_r;
   logic            unf_r;

   logic [PC_W-1:0] target_s;
   logic [PC_W-1:0] pc_inc_s;
   logic [PC_W-1:0] next_pc_s;
   logic            push_s;
   logic            pop_s;
   logic            set_done_s;
   logic            set_ovf_s;
   logic            set_unf_s;
   logic [PC_W-1:0] ras_top_s;
   logic            ras_full_s;
   logic            ras_empty_s;

   // Table read is combinational from the registered array, so a same-cycle
   // write to the same index is seen only after the edge.
   assign target_s = lut_r[lut_idx];
   assign pc_inc_s = pc_r + PC_W'(1);

   ret_addr_stack #(
      .DEPTH (RAS_DEPTH),
      .W     (PC_W)
   ) u_ras (
      .clk       (CLK),
      .rst       (START),
      .push      (push_s),
      .pop       (pop_s),
      .push_data (pc_inc_s),
      .top_data  (ras_top_s),
      .full      (ras_full_s),
      .empty     (ras_empty_s)
   );

   // Next-PC selection and stack/flag side effects, in strobe priority order.
   always_comb begin
      next_pc_s  = pc_r;
      push_s     = 1'b0;
      pop_s      = 1'b0;
      set_done_s = 1'b0;
      set_ovf_s  = 1'b0;
      set_unf_s  = 1'b0;
      if (done_r) begin
         next_pc_s = pc_r;
      end else if (halt) begin
         next_pc_s  = pc_r;
         set_done_s = 1'b1;
      end else if (stall) begin
         next_pc_s = pc_r;
      end else if (ret) begin
         if (!ras_empty_s) begin
            pop_s     = 1'b1;
            next_pc_s = ras_top_s;
         end else begin
            next_pc_s = pc_inc_s;
            set_unf_s = 1'b1;
         end
      end else if (call) begin
         push_s    = 1'b1;
         next_pc_s = target_s;
         set_ovf_s = ras_full_s;
      end else if (br_abs) begin
         next_pc_s = target_s;
      end else if ((br_rel_z && zero_r) || (br_rel_nz && !zero_r)) begin
         // Table entry is a two's-complement offset; sum wraps modulo 2^PC_W.
         next_pc_s = pc_r + target_s;
      end else begin
         next_pc_s = pc_inc_s;
      end
   end

   // PC, sticky DONE and sticky stack error flags.
   always_ff @(posedge CLK) begin
      if (START) begin
         pc_r   <= '0;
         done_r <= 1'b0;
         ovf_r  <= 1'b0;
         unf_r  <= 1'b0;
      end else begin
         pc_r <= next_pc_s;
         if (set_done_s) begin
            done_r <= 1'b1;
         end
         if (set_ovf_s) begin
            ovf_r <= 1'b1;
         end
         if (set_unf_s) begin
            unf_r <= 1'b1;
         end
      end
   end

   // Zero flag loads even while stalled or halted.
   always_ff @(posedge CLK) begin
      if (START) begin
         zero_r <= 1'b0;
      end else if (flag_we) begin
         zero_r <= flag_zero_in;
      end
   end

   // Target table; writes are honoured while stalled or halted.
   always_ff @(posedge CLK) begin
      if (START) begin
         for (int i = 0; i < LUT_DEPTH; i++) begin
            lut_r[i] <= '0;
         end
      end else if (lut_we) begin
         lut_r[lut_waddr] <= lut_wdata;
      end
   end

   assign PC            = pc_r;
   assign DONE          = done_r;
   assign zero_flag     = zero_r;
   assign ras_overflow  = ovf_r;
   assign ras_underflow = unf_r;

endmodule
